// File: rtl/lr_check_sequencer_if.sv
// lr_check_sequencer_if: paired left/right disparity input streams and the checked output stream.
interface lr_check_sequencer_if #(
  parameter int DISP_WIDTH = 8
) ();
  logic [DISP_WIDTH:0] l_data;
  logic [DISP_WIDTH:0] r_data;
  logic [DISP_WIDTH:0] out_data;
  logic l_valid;
  logic r_valid;
  logic in_ready;
  logic out_valid;
  logic out_ready;
  modport master (
    output l_data, l_valid, r_data, r_valid, out_ready,
    input  in_ready, out_data, out_valid
  );
  modport slave (
    input  l_data, l_valid, r_data, r_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/lr_check_sequencer.sv
// lr_check_sequencer: feeds the left-right check core, tracks its 2-advance pipeline and streams masked results.
module lr_check_sequencer #(
  parameter int MAXDISPARITY = 64,
  parameter int DISP_WIDTH   = 8,
  parameter int IMG_WIDTH    = 640,
  parameter int IMG_HEIGHT   = 480,
  parameter int COL_W        = 11,
  parameter int ROW_W        = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  lr_check_sequencer_if.slave   io,
  output logic                  core_en,
  output logic                  core_pixel_en,
  output logic [DISP_WIDTH:0]   core_disp_left,
  output logic [DISP_WIDTH:0]   core_disp_right,
  input  logic [DISP_WIDTH:0]   core_disp_out,
  output logic                  frame_done,
  output logic                  sync_err,
  output logic [15:0]           frame_cnt
);
  localparam int CNT_W = COL_W + ROW_W;
  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(IMG_WIDTH * IMG_HEIGHT - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);
  localparam logic [COL_W-1:0] MAXD     = COL_W'(MAXDISPARITY);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [1:0]       vld_q, vld_d;
  logic [CNT_W-1:0] icnt_q, icnt_d;
  logic [COL_W-1:0] ocol_q, ocol_d;
  logic [ROW_W-1:0] orow_q, orow_d;
  logic             sync_err_q, sync_err_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic             l_sof, r_sof, can_adv, both, start, take, adv, hs, col_end;
  logic             unused_core_msb;

  always_comb begin
    l_sof   = io.l_data[DISP_WIDTH];
    r_sof   = io.r_data[DISP_WIDTH];
    can_adv = !vld_q[1] | io.out_ready;
    both    = io.l_valid & io.r_valid;
    start   = (state_q == IDLE) & both & enable & l_sof;
    take    = start | ((state_q == RUN) & both & can_adv);
    adv     = take | ((state_q == FLUSH) & can_adv & (vld_q != 2'b00));
    hs      = vld_q[1] & io.out_ready;
    col_end = ocol_q == LAST_COL;
    // a handshake without an advance retires the output token; the core holds stage 1
    vld_d       = adv ? {vld_q[0], take} : {vld_q[1] & !hs, vld_q[0]};
    icnt_d      = take ? icnt_q + 1'b1 : icnt_q;
    ocol_d      = hs ? (col_end ? '0 : ocol_q + 1'b1) : ocol_q;
    orow_d      = (hs & col_end) ? orow_q + 1'b1 : orow_q;
    state_d     = (state_q == DONE) ? IDLE :
                  (state_q == FLUSH) ? ((vld_d == 2'b00) ? DONE : FLUSH) :
                  take ? ((icnt_q == LAST_PIX) ? FLUSH : RUN) : state_q;
    sync_err_d  = sync_err_q | (take & ((l_sof ^ r_sof) | (l_sof & (icnt_q != '0))));
    frame_cnt_d = frame_cnt_q + {15'd0, state_q == DONE};
    if (state_q == DONE) begin
      icnt_d = '0;
      ocol_d = '0;
      orow_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      vld_q       <= 2'b00;
      icnt_q      <= '0;
      ocol_q      <= '0;
      orow_q      <= '0;
      sync_err_q  <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      vld_q       <= vld_d;
      icnt_q      <= icnt_d;
      ocol_q      <= ocol_d;
      orow_q      <= orow_d;
      sync_err_q  <= sync_err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign io.in_ready       = (state_q == IDLE) | ((state_q == RUN) & can_adv);
  assign io.out_valid      = vld_q[1];
  assign io.out_data       = {(ocol_q == '0) & (orow_q == '0),
                              (ocol_q < MAXD) ? {DISP_WIDTH{1'b0}} : core_disp_out[DISP_WIDTH-1:0]};
  assign core_en           = state_q != IDLE;
  assign core_pixel_en     = adv;
  assign core_disp_left    = take ? io.l_data : '0;
  assign core_disp_right   = take ? io.r_data : '0;
  assign frame_done        = state_q == DONE;
  assign sync_err          = sync_err_q;
  assign frame_cnt         = frame_cnt_q;
  assign unused_core_msb   = core_disp_out[DISP_WIDTH];
endmodule

// File: tb/tb_lr_check_sequencer.sv
// tb_lr_check_sequencer: directed frames against a small core model and an expected-output table.
module tb_lr_check_sequencer;
  localparam int W = 80, H = 2, MD = 16, N = W * H, DW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic core_en, core_pixel_en, frame_done, sync_err;
  logic [DW:0] core_disp_left, core_disp_right, core_disp_out;
  logic [15:0] frame_cnt;

  lr_check_sequencer_if #(.DISP_WIDTH(DW)) bus ();

  lr_check_sequencer #(
    .MAXDISPARITY(MD), .DISP_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H), .COL_W(11), .ROW_W(10)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .io(bus),
    .core_en(core_en), .core_pixel_en(core_pixel_en),
    .core_disp_left(core_disp_left), .core_disp_right(core_disp_right),
    .core_disp_out(core_disp_out), .frame_done(frame_done),
    .sync_err(sync_err), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int oidx = 0, fd_cnt = 0, fd_cyc = 0, last_acc = 0, cyc = 0;
  bit rnd_ready = 0;
  bit stall_prev = 0;
  logic [DW:0] prev_d;
  logic [DW-1:0] lpix [N];
  logic [DW-1:0] rpix [N];
  logic [DW:0] expv [N];
  logic [DW:0] c1, c2;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] fcore(input logic [DW-1:0] l, input logic [DW-1:0] r);
    logic [DW-1:0] d;
    d = (l > r) ? l - r : r - l;
    return (d <= 1) ? l : '0;
  endfunction

  // two-stage check core; MSB carries junk the sequencer must ignore
  always @(posedge clk) begin
    if (!rst_n) begin
      c1 <= '0;
      c2 <= '0;
    end else if (core_pixel_en) begin
      c1 <= {core_disp_left[DW], fcore(core_disp_left[DW-1:0], core_disp_right[DW-1:0])};
      c2 <= c1;
    end
  end
  assign core_disp_out = c2;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  always @(negedge clk) begin
    if (frame_done) begin
      fd_cnt++;
      fd_cyc = cyc;
    end
    if (bus.out_valid) begin
      if (stall_prev) chk("stall_stable", bus.out_data, prev_d);
      if (!bus.out_ready) chk("stall_pen", core_pixel_en, 0);
      else begin
        if (oidx < N) chk($sformatf("out%0d", oidx), bus.out_data, expv[oidx]);
        else chk("extra_beat", oidx, N - 1);
        oidx++;
      end
    end
    stall_prev = bus.out_valid & !bus.out_ready;
    prev_d = bus.out_data;
  end

  task automatic prep();
    for (int i = 0; i < N; i++)
      expv[i] = {i == 0, (i % W < MD) ? 8'd0 : fcore(lpix[i], rpix[i])};
    oidx = 0;
  endtask

  task automatic send_beat(input logic [DW:0] l, input logic [DW:0] r);
    int t;
    t = 0;
    bus.l_data = l;
    bus.r_data = r;
    bus.l_valid = 1'b1;
    bus.r_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) chk("accept_timeout", t, 0);
    @(posedge clk);
    #1;
    last_acc = cyc;
    bus.l_valid = 1'b0;
    bus.r_valid = 1'b0;
  endtask

  task automatic drop_beat(input logic [DW:0] l, input logic [DW:0] r);
    bus.l_data = l;
    bus.r_data = r;
    bus.l_valid = 1'b1;
    bus.r_valid = 1'b1;
    @(negedge clk);
    chk("drop_pen", core_pixel_en, 0);
    chk("drop_core_en", core_en, 0);
    @(posedge clk);
    #1;
    bus.l_valid = 1'b0;
    bus.r_valid = 1'b0;
  endtask

  task automatic send_frame(input bit lsof, input bit rsof, input int gap_at);
    for (int i = 0; i < N; i++) begin
      if (i == gap_at) begin
        bus.l_data = {1'b0, lpix[i]};
        bus.l_valid = 1'b1;
        bus.r_valid = 1'b0;
        repeat (10) begin
          @(negedge clk);
          chk("gap_ready", bus.in_ready, 1);
          chk("gap_pen", core_pixel_en, 0);
          @(posedge clk);
          #1;
        end
      end
      send_beat({i == 0 && lsof, lpix[i]}, {i == 0 && rsof, rpix[i]});
    end
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (!frame_done && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("frame_done_seen", frame_done, 1);
    @(posedge clk);
    #1;
    chk("frame_done_pulse", frame_done, 0);
    chk("beats", oidx, N);
  endtask

  initial begin
    int fdc;
    bus.l_data = '0;
    bus.r_data = '0;
    bus.l_valid = 1'b0;
    bus.r_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_core_en", core_en, 0);
    chk("rst_pen", core_pixel_en, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_sync_err", sync_err, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    @(posedge clk);
    #1;
    // zeros frame, full-rate
    enable = 1'b1;
    for (int i = 0; i < N; i++) begin lpix[i] = 0; rpix[i] = 0; end
    prep();
    send_frame(1, 1, -1);
    wait_done();
    chk("t1_done_delay", fd_cyc - last_acc, 2);
    chk("t1_frame_cnt", frame_cnt, 1);
    chk("t1_sync_err", sync_err, 0);
    chk("t1_idle_core_en", core_en, 0);
    // matching 5s with a right-valid gap mid-line
    for (int i = 0; i < N; i++) begin lpix[i] = 5; rpix[i] = 5; end
    prep();
    send_frame(1, 1, 50);
    wait_done();
    chk("t2_frame_cnt", frame_cnt, 2);
    // mismatching disparities under random back-pressure
    for (int i = 0; i < N; i++) begin lpix[i] = 5; rpix[i] = 9; end
    prep();
    rnd_ready = 1;
    send_frame(1, 1, -1);
    wait_done();
    rnd_ready = 0;
    chk("t3_frame_cnt", frame_cnt, 3);
    chk("t3_sync_err", sync_err, 0);
    // pre-frame junk dropped, then a frame whose right SOF is missing
    enable = 1'b0;
    drop_beat({1'b1, 8'd3}, {1'b1, 8'd3});
    enable = 1'b1;
    drop_beat({1'b0, 8'd4}, {1'b0, 8'd4});
    drop_beat({1'b0, 8'd6}, {1'b0, 8'd6});
    chk("t4_pre_out_valid", bus.out_valid, 0);
    chk("t4_pre_frame_cnt", frame_cnt, 3);
    for (int i = 0; i < N; i++) begin
      lpix[i] = 8'((i * 7) % 50 + 10);
      rpix[i] = lpix[i] + 8'(i % 3);
    end
    prep();
    send_frame(1, 0, -1);
    wait_done();
    chk("t4_sync_err", sync_err, 1);
    chk("t4_frame_cnt", frame_cnt, 4);
    repeat (5) @(posedge clk);
    #1;
    chk("t4_sync_sticky", sync_err, 1);
    // reset at pixel 40 abandons the frame
    for (int i = 0; i < N; i++) begin lpix[i] = 5; rpix[i] = 5; end
    prep();
    for (int i = 0; i < 40; i++) send_beat({i == 0, lpix[i]}, {i == 0, rpix[i]});
    fdc = fd_cnt;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("t5_out_valid", bus.out_valid, 0);
    chk("t5_core_en", core_en, 0);
    chk("t5_pen", core_pixel_en, 0);
    chk("t5_sync_err", sync_err, 0);
    chk("t5_frame_cnt", frame_cnt, 0);
    chk("t5_frame_done", frame_done, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("t5_no_done", fd_cnt, fdc);
    prep();
    send_frame(1, 1, -1);
    wait_done();
    chk("t5_after_frame_cnt", frame_cnt, 1);
    chk("t5_after_sync_err", sync_err, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule
